// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundles the pipeline-control signals that pass between
// the hazard scheduler and the datapath.
//   en        - global pipeline advance (0 = every stage holds)
//   instr_D   - instruction word currently in decode
//   stall     - freeze PC and F/D register; bubble into D/E register
//   fwd_rs_D  - D-stage rs select: 0 RF, 1 E (jal PC+8), 2 M, 3 W
//   fwd_rt_D  - D-stage rt select, same encoding
//   fwd_rs_E  - ALU A select: 0 D/E register, 1 M result, 2 W write data
//   fwd_rt_E  - ALU B / store-data select, same encoding
//   fwd_rt_M  - sw write data in M: 0 E/M register, 1 W write data
//   stall_cnt - stall cycle counter (zero unless HAZARD_STALL_CNT_EN)
// master: datapath side. slave: hazard_ctrl side.
interface hazard_ctrl_if;
  logic        en;
  logic [31:0] instr_D;
  logic        stall;
  logic [1:0]  fwd_rs_D;
  logic [1:0]  fwd_rt_D;
  logic [1:0]  fwd_rs_E;
  logic [1:0]  fwd_rt_E;
  logic        fwd_rt_M;
  logic [31:0] stall_cnt;

  modport master (
    output en, instr_D,
    input  stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M, stall_cnt
  );

  modport slave (
    input  en, instr_D,
    output stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/forward scheduler for the 5-stage MIPS pipeline.
// Decodes the instruction in D, tracks {dst, tnew, rs, rt} for E, M and W in
// a shadow pipeline, and drives stall plus every forwarding mux select.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high; turns all shadow stages into bubbles
//   bus   - hazard_ctrl_if.slave (en, instr_D in; stall, fwd_*, stall_cnt out)
// Parameters:
//   REG_JAL - destination register written by jal
//   TNEW_LW - cycles until a lw result exists, counted from entry into E
// Optional feature: define HAZARD_STALL_CNT_EN to build the stall_cnt
// counter (cycles with en=1 and stall=1); otherwise stall_cnt is 0.
module hazard_ctrl #(
  parameter logic [4:0]  REG_JAL = 5'd31,
  parameter int unsigned TNEW_LW = 2
) (
  input logic          clk,
  input logic          reset,
  hazard_ctrl_if.slave bus
);

  typedef struct packed {
    logic [4:0] dst;
    logic [1:0] tnew;
    logic [4:0] rs;
    logic [4:0] rt;
  } stage_t;

  stage_t e_q, m_q, w_q;
  stage_t e_d, m_d, w_d;
  stage_t d_stage;
  logic [1:0] tuse_rs, tuse_rt;
  logic       stall;

  logic [5:0] op, fn;
  assign op = bus.instr_D[31:26];
  assign fn = bus.instr_D[5:0];

  // Only registers an instruction actually reads are recorded as sources,
  // so the E/M selects never fire for operand fields that carry a dst.
  always_comb begin
    d_stage = '0;
    tuse_rs = 2'd3;
    tuse_rt = 2'd3;
    case (op)
      6'h00: begin
        case (fn)
          6'h21, 6'h23: begin // addu, subu
            d_stage.dst  = bus.instr_D[15:11];
            d_stage.tnew = 2'd1;
            d_stage.rs   = bus.instr_D[25:21];
            d_stage.rt   = bus.instr_D[20:16];
            tuse_rs      = 2'd1;
            tuse_rt      = 2'd1;
          end
          6'h08: begin // jr
            d_stage.rs = bus.instr_D[25:21];
            tuse_rs    = 2'd0;
          end
          default: ;
        endcase
      end
      6'h0D: begin // ori
        d_stage.dst  = bus.instr_D[20:16];
        d_stage.tnew = 2'd1;
        d_stage.rs   = bus.instr_D[25:21];
        tuse_rs      = 2'd1;
      end
      6'h0F: begin // lui
        d_stage.dst  = bus.instr_D[20:16];
        d_stage.tnew = 2'd1;
      end
      6'h23: begin // lw
        d_stage.dst  = bus.instr_D[20:16];
        d_stage.tnew = 2'(TNEW_LW);
        d_stage.rs   = bus.instr_D[25:21];
        tuse_rs      = 2'd1;
      end
      6'h2B: begin // sw
        d_stage.rs = bus.instr_D[25:21];
        d_stage.rt = bus.instr_D[20:16];
        tuse_rs    = 2'd1;
        tuse_rt    = 2'd2;
      end
      6'h04: begin // beq
        d_stage.rs = bus.instr_D[25:21];
        d_stage.rt = bus.instr_D[20:16];
        tuse_rs    = 2'd0;
        tuse_rt    = 2'd0;
      end
      6'h03: begin // jal
        d_stage.dst  = REG_JAL;
        d_stage.tnew = 2'd0;
      end
      default: ;
    endcase
  end

  // Only the youngest producer of s matters; an older match is stale.
  function automatic logic src_stall(input logic [4:0] s, input logic [1:0] tuse,
                                     input stage_t e, input stage_t m);
    logic hit;
    hit = 1'b0;
    if (s != '0) begin
      if (e.dst == s)      hit = (tuse < e.tnew);
      else if (m.dst == s) hit = (tuse < m.tnew);
    end
    return hit;
  endfunction

  function automatic logic [1:0] sel_d(input logic [4:0] s, input stage_t e,
                                       input stage_t m, input stage_t w);
    logic [1:0] sel;
    sel = 2'd0;
    if (s != '0) begin
      if (e.dst == s && e.tnew == '0)      sel = 2'd1;
      else if (m.dst == s && m.tnew == '0) sel = 2'd2;
      else if (w.dst == s && w.tnew == '0) sel = 2'd3;
    end
    return sel;
  endfunction

  function automatic logic [1:0] sel_e(input logic [4:0] s, input stage_t m,
                                       input stage_t w);
    logic [1:0] sel;
    sel = 2'd0;
    if (s != '0) begin
      if (m.dst == s && m.tnew == '0)      sel = 2'd1;
      else if (w.dst == s && w.tnew == '0) sel = 2'd2;
    end
    return sel;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] t);
    return (t == '0) ? 2'd0 : t - 2'd1;
  endfunction

  assign stall = src_stall(d_stage.rs, tuse_rs, e_q, m_q) |
                 src_stall(d_stage.rt, tuse_rt, e_q, m_q);

  assign bus.stall    = stall;
  assign bus.fwd_rs_D = sel_d(d_stage.rs, e_q, m_q, w_q);
  assign bus.fwd_rt_D = sel_d(d_stage.rt, e_q, m_q, w_q);
  assign bus.fwd_rs_E = sel_e(e_q.rs, m_q, w_q);
  assign bus.fwd_rt_E = sel_e(e_q.rt, m_q, w_q);
  assign bus.fwd_rt_M = (m_q.rt != '0) && (w_q.dst == m_q.rt) && (w_q.tnew == '0);

  always_comb begin
    e_d = e_q;
    m_d = m_q;
    w_d = w_q;
    if (bus.en) begin
      e_d      = stall ? '0 : d_stage;
      m_d      = e_q;
      m_d.tnew = sat_dec(e_q.tnew);
      w_d      = m_q;
      w_d.tnew = sat_dec(m_q.tnew);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.en && stall) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign bus.stall_cnt = stall_cnt_q;
`else
  assign bus.stall_cnt = '0;
`endif

  // Fields that exist in the shadow stages but are never consulted.
  logic unused_bits;
  assign unused_bits = ^{bus.instr_D[10:6], m_q.rs, w_q.rs, w_q.rt};

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  logic clk;
  logic reset;
  int unsigned n_checks;
  int unsigned n_pass;

  hazard_ctrl_if hif ();

  hazard_ctrl #(.REG_JAL(5'd31), .TNEW_LW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

`ifdef HAZARD_STALL_CNT_EN
  localparam logic [31:0] CNT_ONE = 32'd1;
`else
  localparam logic [31:0] CNT_ONE = 32'd0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, got, exp);
  endtask

  function automatic logic [31:0] r_type(input logic [5:0] fn, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Apply instr for the current cycle and let combinational outputs settle.
  task automatic put(input logic [31:0] instr);
    hif.instr_D = instr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    put(32'h0);
    for (int unsigned i = 0; i < 3; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    reset       = 1'b1;
    hif.en      = 1'b1;
    hif.instr_D = 32'h0;
    tick();
    reset = 1'b0;
    #1;
    check("rst_stall", 32'(hif.stall), 0);
    check("rst_fwd", 32'({hif.fwd_rs_D, hif.fwd_rt_D, hif.fwd_rs_E, hif.fwd_rt_E, hif.fwd_rt_M}), 0);
    check("rst_cnt", hif.stall_cnt, 0);

    // lw $1 ; addu $2,$1,$1 : one stall, then W forwarding in E
    put(i_type(6'h23, 5'd0, 5'd1, 16'd0));
    check("lw_nostall", 32'(hif.stall), 0);
    tick();
    put(r_type(6'h21, 5'd1, 5'd1, 5'd2));
    check("lwuse_stall1", 32'(hif.stall), 1);
    tick();
    check("lwuse_stall_end", 32'(hif.stall), 0);
    tick();
    put(32'h0);
    check("lwuse_fwd_rs_E", 32'(hif.fwd_rs_E), 2);
    check("lwuse_fwd_rt_E", 32'(hif.fwd_rt_E), 2);
    flush();

    // lw $1 ; beq $1,$0 : two stalls, then W forwarding in D
    put(i_type(6'h23, 5'd0, 5'd1, 16'd0));
    tick();
    put(i_type(6'h04, 5'd1, 5'd0, 16'd4));
    check("beq_stall1", 32'(hif.stall), 1);
    tick();
    check("beq_stall2", 32'(hif.stall), 1);
    tick();
    check("beq_stall_end", 32'(hif.stall), 0);
    check("beq_fwd_rs_D", 32'(hif.fwd_rs_D), 3);
    check("beq_fwd_rt_D", 32'(hif.fwd_rt_D), 0);
    flush();

    // ori $3,$0,5 ; sw $3,0($0) : no stall, M forwarding to store data
    put(i_type(6'h0D, 5'd0, 5'd3, 16'd5));
    tick();
    put(i_type(6'h2B, 5'd0, 5'd3, 16'd0));
    check("orisw_stall", 32'(hif.stall), 0);
    check("orisw_fwd_rt_D", 32'(hif.fwd_rt_D), 0);
    tick();
    put(32'h0);
    check("orisw_fwd_rt_E", 32'(hif.fwd_rt_E), 1);
    check("orisw_fwd_rs_E", 32'(hif.fwd_rs_E), 0);
    tick();
    check("orisw_fwd_rt_M", 32'(hif.fwd_rt_M), 1);
    flush();

    // lw $4 ; sw $4,0($0) : Tuse 2 == Tnew 2, no stall, W forwarding in M
    put(i_type(6'h23, 5'd0, 5'd4, 16'd0));
    tick();
    put(i_type(6'h2B, 5'd0, 5'd4, 16'd0));
    check("lwsw_stall", 32'(hif.stall), 0);
    tick();
    put(32'h0);
    check("lwsw_fwd_rt_E", 32'(hif.fwd_rt_E), 0);
    tick();
    check("lwsw_fwd_rt_M", 32'(hif.fwd_rt_M), 1);
    flush();

    // jal ; jr $31 : E forwarding of PC+8
    put({6'h03, 26'h100});
    tick();
    put(r_type(6'h08, 5'd31, 5'd0, 5'd0));
    check("jaljr_stall", 32'(hif.stall), 0);
    check("jaljr_fwd_rs_D", 32'(hif.fwd_rs_D), 1);
    flush();

    // addu $0,$1,$1 ; addu $2,$0,$0 : $0 never hazards or forwards
    put(r_type(6'h21, 5'd1, 5'd1, 5'd0));
    tick();
    put(r_type(6'h21, 5'd0, 5'd0, 5'd2));
    check("zero_stall", 32'(hif.stall), 0);
    check("zero_fwd_D", 32'({hif.fwd_rs_D, hif.fwd_rt_D}), 0);
    tick();
    put(32'h0);
    check("zero_fwd_E", 32'({hif.fwd_rs_E, hif.fwd_rt_E}), 0);
    tick();
    check("zero_fwd_M", 32'(hif.fwd_rt_M), 0);

    // lw $1 ; addu with en=0 for 3 cycles : stall held, one counted advance
    do_reset();
    check("cnt_cleared", hif.stall_cnt, 0);
    put(i_type(6'h23, 5'd0, 5'd1, 16'd0));
    tick();
    put(r_type(6'h21, 5'd1, 5'd1, 5'd2));
    hif.en = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      check("hold_stall", 32'(hif.stall), 1);
      tick();
    end
    check("hold_cnt", hif.stall_cnt, 0);
    check("hold_stall_last", 32'(hif.stall), 1);
    hif.en = 1'b1;
    tick();
    check("hold_released", 32'(hif.stall), 0);
    check("hold_cnt_one", hif.stall_cnt, CNT_ONE);
    do_reset();
    check("post_rst_cnt", hif.stall_cnt, 0);
    check("post_rst_stall", 32'(hif.stall), 0);

    // reset while stalling drops stall next cycle
    put(i_type(6'h23, 5'd0, 5'd1, 16'd0));
    tick();
    put(r_type(6'h23, 5'd1, 5'd1, 5'd5));
    check("mid_stall", 32'(hif.stall), 1);
    do_reset();
    check("mid_rst_stall", 32'(hif.stall), 0);
    check("mid_rst_fwd", 32'({hif.fwd_rs_D, hif.fwd_rt_D, hif.fwd_rs_E, hif.fwd_rt_E, hif.fwd_rt_M}), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
